johnson_decoder: RTL and testbench
==================================

JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the Johnson code width N; it covers 2N states and WIDTH >= 2.
REQ-002 The block SHALL have parameter ERR_W, default 8, giving the error counter width.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 q  input  WIDTH  sampled Johnson code word.
REQ-006 valid  input  1  sample strobe; q is evaluated only when valid=1.
REQ-007 clear_err  input  1  synchronous clear of err_count.
REQ-008 index  output  $clog2(2*WIDTH)  decoded state index, 0..2N-1.
REQ-009 index_valid  output  1  one-cycle pulse: a legal sample was decoded.
REQ-010 illegal  output  1  one-cycle pulse: the sampled word is not a Johnson code.
REQ-011 skip  output  1  one-cycle pulse: a legal code arrived that is not adjacent to the previous index while LOCKED.
REQ-012 dir  output  1  tracked direction; 1 = forward (index increments), 0 = reverse.
REQ-013 locked  output  1  high while the FSM is in LOCKED.
REQ-014 err_count  output  ERR_W  count of illegal and skip events; saturates at all-ones.

Function
REQ-015 Forward sequence SHALL be q_next = {q[N-2:0], ~q[N-1]} from all-zeros; for N=4: 0000,0001,0011,0111,1111,1110,1100,1000 map to indices 0..7.
REQ-016 Legality SHALL require at most one i in 0..N-2 with q[i] != q[i+1].
REQ-017 Decode SHALL be: q[0]=1 gives index = popcount(q); q[0]=0 and popcount=0 gives 0; otherwise index = 2N - popcount(q).
REQ-018 All outputs SHALL be registered, with 1-cycle latency from the valid edge to index/index_valid/illegal/skip.
REQ-019 With valid=0, index, dir, locked and the FSM SHALL hold, and all pulse outputs SHALL be 0.
REQ-020 Adjacency SHALL be defined as new = prev ± 1 mod 2N, so 2N-1 -> 0 is a forward step and 0 -> 2N-1 is a reverse step.
REQ-021 The FSM SHALL have states UNLOCKED, ACQUIRE and LOCKED.
REQ-022 UNLOCKED: a legal sample SHALL store prev and move to ACQUIRE; an illegal sample SHALL stay in UNLOCKED.
REQ-023 ACQUIRE: an adjacent sample SHALL set dir from the step sign and move to LOCKED.
REQ-024 ACQUIRE: a legal but non-adjacent sample, or a repeat, SHALL update prev and stay in ACQUIRE; an illegal sample SHALL move to UNLOCKED.
REQ-025 LOCKED: a same-direction step SHALL update prev; an opposite step SHALL update prev and invert dir; a repeat of prev SHALL change nothing.
REQ-026 LOCKED: a legal non-adjacent sample SHALL pulse skip, update prev and move to ACQUIRE.
REQ-027 LOCKED: an illegal sample SHALL pulse illegal and move to UNLOCKED.
REQ-028 An illegal sample SHALL pulse illegal in any state, hold index and keep index_valid=0.
REQ-029 skip SHALL pulse only in LOCKED, and index_valid SHALL also pulse with the new index on a skip.
REQ-030 err_count SHALL increment by 1 on each illegal or skip event and hold at 2^ERR_W-1.
REQ-031 When clear_err and an increment occur in the same cycle, clear SHALL win and err_count SHALL become 0.
REQ-032 illegal and skip SHALL be mutually exclusive per sample.

Reset
REQ-033 Reset assertion SHALL immediately force: FSM=UNLOCKED, index=0, prev=0, dir=1, locked=0, all pulse outputs=0, err_count=0, including mid-operation.
REQ-034 After reset release, the first valid sample SHALL be treated as an UNLOCKED-state sample.

Structure
REQ-035 Package johnson_pkg SHALL hold the FSM state typedef (UNLOCKED, ACQUIRE, LOCKED) and the index-width helper constant/function.
REQ-036 Legality check and index decode SHALL be a combinational sub-module johnson_code_decode (inputs q; outputs legal, idx), instantiated once.

Verification (WIDTH=4, ERR_W=8)
REQ-037 Forward walk 0000..1000 then 0000, valid every cycle: indices 0..7,0; locked=1 from the 2nd decode; dir=1; err_count=0.
REQ-038 Locked at index 3, feed 0011: index=2, dir=0, no skip; then 0001: index=1, dir stays 0.
REQ-039 Locked at index 1, feed 1100: skip=1, index=6, index_valid=1, err_count=1, locked=0 next cycle.
REQ-040 Locked, feed 0101: illegal=1, index_valid=0, index held, err_count+1, FSM=UNLOCKED.
REQ-041 Force 260 illegal samples: err_count=255; clear_err coincident with an illegal sample: err_count=0.
REQ-042 Assert reset asynchronously mid-walk, between clock edges: all outputs zero except dir=1, immediately; after release, first legal sample moves to ACQUIRE.

Source files
------------

// File: rtl/johnson_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : johnson_pkg
// Brief    : Shared types and helpers for the Johnson-code decoder slice:
//            tracking FSM state encoding and index-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package johnson_pkg;

    // Tracking FSM states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } jstate_t;

    // Bits needed to hold an index in 0..2N-1 for an N-bit Johnson code.
    function automatic int idx_width(input int n);
        return $clog2(2 * n);
    endfunction

endpackage : johnson_pkg
`default_nettype wire

// File: rtl/johnson_decoder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : johnson_decoder_if
// Brief    : Sample/result bundle between a Johnson-code source (master) and
//            the decoder (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface johnson_decoder_if
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    localparam int IDX_W = idx_width(WIDTH);

    logic [WIDTH-1:0] q;
    logic             valid;
    logic             clear_err;
    logic [IDX_W-1:0] index;
    logic             index_valid;
    logic             illegal;
    logic             skip;
    logic             dir;
    logic             locked;
    logic [ERR_W-1:0] err_count;

    modport master (
        output q, valid, clear_err,
        input  index, index_valid, illegal, skip, dir, locked, err_count
    );

    modport slave (
        input  q, valid, clear_err,
        output index, index_valid, illegal, skip, dir, locked, err_count
    );

endinterface : johnson_decoder_if
`default_nettype wire

// File: rtl/johnson_code_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : johnson_code_decode
// Brief    : Combinational legality check and index decode of one N-bit
//            Johnson code word.
// Revision : 1.0 - initial release
// ============================================================================
module johnson_code_decode #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 3
) (
    input  wire logic [WIDTH-1:0] q_i,
    output logic                  legal_o,
    output logic [IDX_W-1:0]      idx_o
);

    int w_trans;
    int w_pop;
    int w_idx;

    // A Johnson word has at most one 0/1 boundary between adjacent bits; the
    // popcount together with bit 0 tells which half of the cycle we are in.
    always_comb begin
        w_trans = 0;
        w_pop   = 0;
        w_idx   = 0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (q_i[i] != q_i[i+1]) begin
                w_trans = w_trans + 1;
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (q_i[i]) begin
                w_pop = w_pop + 1;
            end
        end
        if (q_i[0]) begin
            w_idx = w_pop;
        end else if (w_pop == 0) begin
            w_idx = 0;
        end else begin
            w_idx = 2 * WIDTH - w_pop;
        end
        legal_o = (w_trans <= 1);
        idx_o   = IDX_W'(w_idx);
    end

endmodule : johnson_code_decode
`default_nettype wire

// File: rtl/johnson_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : johnson_decoder
// Brief    : Decodes sampled Johnson code words into a state index, tracks
//            direction with an UNLOCKED/ACQUIRE/LOCKED FSM, and counts
//            illegal and skipped samples in a saturating error counter.
// Revision : 1.0 - initial release
// ============================================================================
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
) (
    input wire logic         clk,
    input wire logic         reset,
    johnson_decoder_if.slave bus
);

    localparam int               IDX_W     = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] c_LAST    = IDX_W'(2 * WIDTH - 1);
    localparam logic [IDX_W-1:0] c_ONE     = IDX_W'(1);
    localparam logic [ERR_W-1:0] c_ERR_MAX = '1;

    // The registered index doubles as the "previous index" for adjacency:
    // both are updated by exactly the same legal samples and reset to 0.
    jstate_t          state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             dir_q, dir_d;
    logic             locked_q;
    logic             index_valid_q, index_valid_d;
    logic             illegal_q, illegal_d;
    logic             skip_q, skip_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             w_err_inc;

    logic             w_legal;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_fwd_idx;
    logic [IDX_W-1:0] w_rev_idx;
    logic             w_is_fwd;
    logic             w_is_rev;
    logic             w_is_rep;

    johnson_code_decode #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_decode (
        .q_i     (bus.q),
        .legal_o (w_legal),
        .idx_o   (w_idx)
    );

    // Neighbours of the previous index, wrapping modulo 2N.
    always_comb begin
        w_fwd_idx = (index_q == c_LAST) ? '0 : index_q + c_ONE;
        w_rev_idx = (index_q == '0) ? c_LAST : index_q - c_ONE;
        w_is_fwd  = (w_idx == w_fwd_idx);
        w_is_rev  = (w_idx == w_rev_idx);
        w_is_rep  = (w_idx == index_q);
    end

    // Next-state, pulse and error-increment logic for one sample.
    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        dir_d         = dir_q;
        index_valid_d = 1'b0;
        illegal_d     = 1'b0;
        skip_d        = 1'b0;
        w_err_inc     = 1'b0;
        if (bus.valid) begin
            if (!w_legal) begin
                illegal_d = 1'b1;
                w_err_inc = 1'b1;
                state_d   = UNLOCKED;
            end else begin
                index_valid_d = 1'b1;
                index_d       = w_idx;
                unique case (state_q)
                    UNLOCKED: begin
                        state_d = ACQUIRE;
                    end
                    ACQUIRE: begin
                        if (w_is_fwd) begin
                            dir_d   = 1'b1;
                            state_d = LOCKED;
                        end else if (w_is_rev) begin
                            dir_d   = 1'b0;
                            state_d = LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (w_is_fwd) begin
                            dir_d = 1'b1;
                        end else if (w_is_rev) begin
                            dir_d = 1'b0;
                        end else if (!w_is_rep) begin
                            skip_d    = 1'b1;
                            w_err_inc = 1'b1;
                            state_d   = ACQUIRE;
                        end
                    end
                    default: begin
                        state_d = UNLOCKED;
                    end
                endcase
            end
        end
    end

    // Saturating error counter; a clear overrides a same-cycle increment.
    always_comb begin
        err_d = err_q;
        if (bus.clear_err) begin
            err_d = '0;
        end else if (w_err_inc && (err_q != c_ERR_MAX)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    // State and output registers; reset takes effect without a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= UNLOCKED;
            index_q       <= '0;
            dir_q         <= 1'b1;
            locked_q      <= 1'b0;
            index_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            skip_q        <= 1'b0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            dir_q         <= dir_d;
            locked_q      <= (state_d == LOCKED);
            index_valid_q <= index_valid_d;
            illegal_q     <= illegal_d;
            skip_q        <= skip_d;
            err_q         <= err_d;
        end
    end

    assign bus.index       = index_q;
    assign bus.index_valid = index_valid_q;
    assign bus.illegal     = illegal_q;
    assign bus.skip        = skip_q;
    assign bus.dir         = dir_q;
    assign bus.locked      = locked_q;
    assign bus.err_count   = err_q;

endmodule : johnson_decoder
`default_nettype wire

// File: tb/tb_johnson_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_johnson_decoder
// Brief    : Scoreboard bench for johnson_decoder (WIDTH=4, ERR_W=8) driven by
//            directed code words with hand-computed expected responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_johnson_decoder;

    typedef struct {
        logic [3:0] code;
        int         idx;
        bit         iv;
        bit         ill;
        bit         sk;
        bit         dir;
        bit         lk;
        int         err;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    johnson_decoder_if #(.WIDTH(4), .ERR_W(8)) bus ();

    johnson_decoder #(
        .WIDTH (4),
        .ERR_W (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Drive one sample at the falling edge and record its expected response.
    task automatic send(input logic [3:0] code, input int idx, input bit iv,
                        input bit ill, input bit sk, input bit dir, input bit lk,
                        input int err, input bit clr = 1'b0);
        exp_t e;
        @(negedge clk);
        bus.q         = code;
        bus.valid     = 1'b1;
        bus.clear_err = clr;
        e.code = code; e.idx = idx; e.iv = iv; e.ill = ill; e.sk = sk;
        e.dir  = dir;  e.lk  = lk;  e.err = err;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.valid     = 1'b0;
        bus.clear_err = 1'b0;
    endtask

    // Monitor: every output pulse consumes one expected response.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.index_valid || bus.illegal || bus.skip) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got pulse iv=%0b ill=%0b skip=%0b, expected none",
                             bus.index_valid, bus.illegal, bus.skip);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("index[%b]", e.code),       int'(bus.index),       e.idx);
                    chk($sformatf("index_valid[%b]", e.code), int'(bus.index_valid), int'(e.iv));
                    chk($sformatf("illegal[%b]", e.code),     int'(bus.illegal),     int'(e.ill));
                    chk($sformatf("skip[%b]", e.code),        int'(bus.skip),        int'(e.sk));
                    chk($sformatf("dir[%b]", e.code),         int'(bus.dir),         int'(e.dir));
                    chk($sformatf("locked[%b]", e.code),      int'(bus.locked),      int'(e.lk));
                    chk($sformatf("err_count[%b]", e.code),   int'(bus.err_count),   e.err);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.q         = 4'b0000;
        bus.valid     = 1'b0;
        bus.clear_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_index",  int'(bus.index),     0);
        chk("rst_dir",    int'(bus.dir),       1);
        chk("rst_locked", int'(bus.locked),    0);
        chk("rst_err",    int'(bus.err_count), 0);
        reset = 1'b0;

        // Forward walk with wrap 7 -> 0.
        send(4'b0000, 0, 1, 0, 0, 1, 0, 0);
        send(4'b0001, 1, 1, 0, 0, 1, 1, 0);
        send(4'b0011, 2, 1, 0, 0, 1, 1, 0);
        send(4'b0111, 3, 1, 0, 0, 1, 1, 0);
        send(4'b1111, 4, 1, 0, 0, 1, 1, 0);
        send(4'b1110, 5, 1, 0, 0, 1, 1, 0);
        send(4'b1100, 6, 1, 0, 0, 1, 1, 0);
        send(4'b1000, 7, 1, 0, 0, 1, 1, 0);
        send(4'b0000, 0, 1, 0, 0, 1, 1, 0);
        // Up to index 3, then reverse.
        send(4'b0001, 1, 1, 0, 0, 1, 1, 0);
        send(4'b0011, 2, 1, 0, 0, 1, 1, 0);
        send(4'b0111, 3, 1, 0, 0, 1, 1, 0);
        send(4'b0011, 2, 1, 0, 0, 0, 1, 0);
        send(4'b0001, 1, 1, 0, 0, 0, 1, 0);
        // Skip 1 -> 6 from LOCKED.
        send(4'b1100, 6, 1, 0, 1, 0, 0, 1);
        idle();
        @(posedge clk);
        #1;
        chk("hold_index_valid", int'(bus.index_valid), 0);
        chk("hold_skip",        int'(bus.skip),        0);
        chk("hold_index",       int'(bus.index),       6);
        // ACQUIRE -> LOCKED reverse, repeat, opposite step, illegal.
        send(4'b1110, 5, 1, 0, 0, 0, 1, 1);
        send(4'b1110, 5, 1, 0, 0, 0, 1, 1);
        send(4'b1100, 6, 1, 0, 0, 1, 1, 1);
        send(4'b0101, 6, 0, 1, 0, 1, 0, 2);
        // Reverse wrap 0 -> 7, skip, non-adjacent in ACQUIRE, reacquire.
        send(4'b0000, 0, 1, 0, 0, 1, 0, 2);
        send(4'b1000, 7, 1, 0, 0, 0, 1, 2);
        send(4'b0011, 2, 1, 0, 1, 0, 0, 3);
        send(4'b1111, 4, 1, 0, 0, 0, 0, 3);
        send(4'b0111, 3, 1, 0, 0, 0, 1, 3);
        // Saturation of the error counter, then clear racing an increment.
        for (int k = 1; k <= 260; k++) begin
            send(4'b0101, 3, 0, 1, 0, 0, 0, (3 + k > 255) ? 255 : 3 + k);
        end
        send(4'b0101, 3, 0, 1, 0, 0, 0, 0, 1'b1);
        send(4'b0101, 3, 0, 1, 0, 0, 0, 1);
        send(4'b0000, 0, 1, 0, 0, 0, 0, 1);
        send(4'b1000, 7, 1, 0, 0, 0, 1, 1);
        // Asynchronous reset between clock edges.
        idle();
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_index",       int'(bus.index),       0);
        chk("async_rst_index_valid", int'(bus.index_valid), 0);
        chk("async_rst_dir",         int'(bus.dir),         1);
        chk("async_rst_locked",      int'(bus.locked),      0);
        chk("async_rst_err",         int'(bus.err_count),   0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        send(4'b0011, 2, 1, 0, 0, 1, 0, 0);
        send(4'b0111, 3, 1, 0, 0, 1, 1, 0);
        idle();
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_johnson_decoder
`default_nettype wire
